val2_shifter_pipe: RTL

Pipelined, parametrised Val2 generator for the EXE stage. It produces the ARM data-processing / memory second operand and the shifter carry-out. It covers every addressing mode:
- rotated immediate, immediate-amount shift, register-amount shift (Rs), RRX;
- 12-bit memory offset.

It has two register stages with a valid/ready handshake, so a stalled consumer back-pressures the ID/EXE boundary without losing operands.

---
 rtl/val2_shifter_pipe.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/val2_shifter_pipe.sv
// Two-stage ARM Val2 generator: S1 decodes the addressing mode and effective amount,
// S2 runs a log2(WIDTH)-level barrel shifter and registers Val2/carry. Stall-all handshake.
module val2_shifter_pipe #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             imm,
    input  logic             for_mem,
    input  logic             reg_shift,
    input  logic [11:0]      shifter_operand,
    input  logic [WIDTH-1:0] Val_Rm,
    input  logic [7:0]       Val_Rs,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Val2_out,
    output logic             carry_out
);

    typedef enum logic [1:0] {MODE_MEM, MODE_IMM, MODE_ISH, MODE_RSH} mode_t;
    typedef enum logic [1:0] {SH_LSL, SH_LSR, SH_ASR, SH_ROR} shift_t;

    // One 2:1 mux level per amount bit; each level shifts by a constant power of two.
    function automatic logic [WIDTH-1:0] barrel(
        input logic [WIDTH-1:0] d,
        input logic [SHW-1:0]   k,
        input shift_t           op,
        input logic             fill
    );
        logic [WIDTH-1:0] r;
        int unsigned      s;
        r = d;
        for (int unsigned i = 0; i < SHW; i++) begin
            s = 32'd1 << i;
            if (k[i]) begin
                case (op)
                    SH_LSL:  r = r << s;
                    SH_LSR:  r = r >> s;
                    SH_ASR:  r = (r >> s) | (~({WIDTH{1'b1}} >> s) & {WIDTH{fill}});
                    default: r = (r >> s) | (r << (WIDTH - s));
                endcase
            end
        end
        return r;
    endfunction

    logic             en;
    logic             s1_valid;
    mode_t            s1_mode;
    shift_t           s1_type;
    logic [11:0]      s1_opnd;
    logic [WIDTH-1:0] s1_rm;
    logic             s1_c;
    logic [8:0]       s1_n;

    mode_t            d_mode;
    logic [8:0]       d_n;
    logic [8:0]       rot2;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    always_comb begin
        d_mode = MODE_ISH;
        d_n    = '0;
        rot2   = {4'b0, shifter_operand[11:8], 1'b0};
        if (for_mem) begin
            d_mode = MODE_MEM;
        end else if (imm) begin
            d_mode = MODE_IMM;
            d_n    = rot2 & 9'(WIDTH - 1);
        end else if (reg_shift) begin
            d_mode = MODE_RSH;
            d_n    = {1'b0, Val_Rs};
        end else begin
            d_n    = {4'b0, shifter_operand[11:7]};
        end
    end

    logic [WIDTH-1:0] m;
    logic             msb;
    logic [SHW-1:0]   k;
    logic [SHW-1:0]   k_neg;
    logic [SHW-1:0]   k_dec;
    logic             nz;
    logic             big;
    logic             eq;
    logic [WIDTH-1:0] rot_src;
    logic [WIDTH-1:0] sh_res;
    logic [WIDTH-1:0] v_nxt;
    logic             c_nxt;

    assign m       = s1_rm;
    assign msb     = s1_rm[WIDTH-1];
    assign k       = s1_n[SHW-1:0];
    assign k_neg   = ~k + SHW'(1);
    assign k_dec   = k - SHW'(1);
    assign nz      = (s1_n != '0);
    assign big     = (s1_n >= 9'(WIDTH));
    assign eq      = (s1_n == 9'(WIDTH));
    assign rot_src = (s1_mode == MODE_IMM) ? WIDTH'(s1_opnd[7:0]) : m;
    assign sh_res  = barrel(rot_src, k, (s1_mode == MODE_IMM) ? SH_ROR : s1_type, msb);

    // Nonzero immediate amounts follow the register-amount rules, which coincide for n < WIDTH.
    always_comb begin
        v_nxt = '0;
        c_nxt = s1_c;
        case (s1_mode)
            MODE_MEM: begin
                v_nxt = WIDTH'(s1_opnd);
                c_nxt = s1_c;
            end
            MODE_IMM: begin
                v_nxt = sh_res;
                c_nxt = nz ? sh_res[WIDTH-1] : s1_c;
            end
            default: begin
                if (!nz) begin
                    if (s1_mode == MODE_RSH) begin
                        v_nxt = m;
                        c_nxt = s1_c;
                    end else begin
                        case (s1_type)
                            SH_LSL: begin v_nxt = m;                     c_nxt = s1_c; end
                            SH_LSR: begin v_nxt = '0;                    c_nxt = msb;  end
                            SH_ASR: begin v_nxt = {WIDTH{msb}};          c_nxt = msb;  end
                            default: begin v_nxt = {s1_c, m[WIDTH-1:1]}; c_nxt = m[0]; end
                        endcase
                    end
                end else begin
                    case (s1_type)
                        SH_LSL: begin
                            if (big) begin v_nxt = '0; c_nxt = eq ? m[0] : 1'b0; end
                            else     begin v_nxt = sh_res; c_nxt = m[k_neg]; end
                        end
                        SH_LSR: begin
                            if (big) begin v_nxt = '0; c_nxt = eq ? msb : 1'b0; end
                            else     begin v_nxt = sh_res; c_nxt = m[k_dec]; end
                        end
                        SH_ASR: begin
                            if (big) begin v_nxt = {WIDTH{msb}}; c_nxt = msb; end
                            else     begin v_nxt = sh_res; c_nxt = m[k_dec]; end
                        end
                        default: begin
                            if (k == '0) begin v_nxt = m; c_nxt = msb; end
                            else         begin v_nxt = sh_res; c_nxt = m[k_dec]; end
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_mode   <= MODE_MEM;
            s1_type   <= SH_LSL;
            s1_opnd   <= '0;
            s1_rm     <= '0;
            s1_c      <= 1'b0;
            s1_n      <= '0;
            out_valid <= 1'b0;
            Val2_out  <= '0;
            carry_out <= 1'b0;
        end else if (en) begin
            s1_valid  <= in_valid;
            s1_mode   <= d_mode;
            s1_type   <= shift_t'(shifter_operand[6:5]);
            s1_opnd   <= shifter_operand;
            s1_rm     <= Val_Rm;
            s1_c      <= carry_in;
            s1_n      <= d_n;
            out_valid <= s1_valid;
            Val2_out  <= v_nxt;
            carry_out <= c_nxt;
        end
    end

endmodule
